data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder_fifo.sv | 45 ++++
 rtl/data_mem_responder.sv | 110 +++++++++++
 tb/tb_data_mem_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared types for the data-memory responder (package ppc_types).
// Holds the default read latency, the response beat type and a popcount helper.
package ppc_types;
   localparam int DATA_MEM_READ_LATENCY = 2;

   // Bit 0 is the MSB, matching the LSU's numbering.
   typedef struct packed {
      logic [0:31] data;
      logic        data_valid;
   } mem_resp_t;

   function automatic int unsigned ones(input logic [31:0] v);
      ones = 0;
      for (int i = 0; i < 32; i++) ones += {31'b0, v[i]};
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_if: LSU <-> data memory request/response channels.
interface data_mem_if;
   logic        to_mem_valid;
   logic        to_mem_ready;
   logic [0:31] mem_address;
   logic [0:3]  mem_write_en;
   logic [0:31] mem_write_data;
   logic [0:3]  mem_read_en;
   logic        from_mem_valid;
   logic        from_mem_ready;
   logic [0:31] mem_read_data;
   logic        mem_read_data_valid;

   modport master (
      output to_mem_valid, mem_address, mem_write_en, mem_write_data, mem_read_en, from_mem_ready,
      input  to_mem_ready, from_mem_valid, mem_read_data, mem_read_data_valid
   );
   modport slave (
      input  to_mem_valid, mem_address, mem_write_en, mem_write_data, mem_read_en, from_mem_ready,
      output to_mem_ready, from_mem_valid, mem_read_data, mem_read_data_valid
   );
endinterface

// File: rtl/data_mem_responder_fifo.sv
// mem_resp_fifo: synchronous FIFO of mem_resp_t with occupancy count.
module mem_resp_fifo
   import ppc_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  mem_resp_t                    i_din,
   output mem_resp_t                    o_dout,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   mem_resp_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          w_push, w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= w_push ? (r_wr == PW'(DEPTH - 1) ? '0 : r_wr + 1'b1) : r_wr;
         r_rd    <= w_pop ? (r_rd == PW'(DEPTH - 1) ? '0 : r_rd + 1'b1) : r_rd;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-enabled data-memory model with fixed-latency, backpressured responses.
// Define DATA_MEM_STATS_EN to add saturating stat_reads/stat_writes/stat_misaligned counters.
module data_mem_responder
   import ppc_types::*;
#(
   parameter int DEPTH_WORDS     = 1024,
   parameter int READ_LATENCY    = DATA_MEM_READ_LATENCY,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   data_mem_if.slave   bus
`ifdef DATA_MEM_STATS_EN
   ,
   output logic [31:0] stat_reads,
   output logic [31:0] stat_writes,
   output logic [31:0] stat_misaligned
`endif
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);

   logic [0:31]             r_mem [DEPTH_WORDS];
   logic                    r_ready_en;
   logic [READ_LATENCY-1:0] r_pipe_v;
   mem_resp_t               r_pipe [READ_LATENCY];
   logic                    w_accept, w_pop, w_is_wr, w_is_rd, w_misal, w_full, w_empty;
   logic [1:0]              w_off;
   logic [AW-1:0]           w_idx;
   logic [0:3]              w_en, w_mask;
   logic [0:31]             w_wdata, w_lanes;
   logic [CW-1:0]           w_count;
   mem_resp_t               w_resp, w_head;
   logic                    w_unused;

   assign w_off    = bus.mem_address[30:31];
   assign w_idx    = bus.mem_address[30-AW:29];
   assign w_unused = &{1'b0, bus.mem_address[0:29-AW]};
   assign w_is_wr  = |bus.mem_write_en;
   assign w_is_rd  = !w_is_wr && |bus.mem_read_en;
   assign w_en     = w_is_wr ? bus.mem_write_en : bus.mem_read_en;
   // A lane pushed past lane 3 by the byte offset makes the access misaligned.
   assign w_misal  = |(w_en & ~(4'b1111 << w_off));
   assign w_mask   = w_en >> w_off;
   assign w_wdata  = bus.mem_write_data >> {w_off, 3'b000};
   assign w_lanes  = {{8{w_mask[0]}}, {8{w_mask[1]}}, {8{w_mask[2]}}, {8{w_mask[3]}}};
   assign w_resp.data       = (w_is_rd && !w_misal) ? (r_mem[w_idx] & w_lanes) << {w_off, 3'b000} : '0;
   assign w_resp.data_valid = w_is_rd && !w_misal;

   // Pipeline plus FIFO never exceeds the FIFO depth, so pushes cannot overflow.
   assign bus.to_mem_ready = r_ready_en && !w_full &&
                             (ones(32'(r_pipe_v)) + {{(32-CW){1'b0}}, w_count}) < RESP_FIFO_DEPTH;
   assign w_accept = bus.to_mem_valid && bus.to_mem_ready;
   assign w_pop    = bus.from_mem_valid && bus.from_mem_ready;

   assign bus.from_mem_valid      = !w_empty;
   assign bus.mem_read_data       = w_empty ? '0 : w_head.data;
   assign bus.mem_read_data_valid = !w_empty && w_head.data_valid;

   always_ff @(posedge clk)
      if (w_accept && w_is_wr && !w_misal)
         for (int l = 0; l < 4; l++)
            if (w_mask[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_ready_en <= 1'b0;
         r_pipe_v   <= '0;
         for (int k = 0; k < READ_LATENCY; k++) r_pipe[k] <= '0;
      end else begin
         r_ready_en  <= 1'b1;
         r_pipe_v[0] <= w_accept;
         r_pipe[0]   <= w_resp;
         for (int k = 1; k < READ_LATENCY; k++) begin
            r_pipe_v[k] <= r_pipe_v[k-1];
            r_pipe[k]   <= r_pipe[k-1];
         end
      end

   mem_resp_fifo #(.DEPTH(RESP_FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_pipe_v[READ_LATENCY-1]),
      .i_pop   (w_pop),
      .i_din   (r_pipe[READ_LATENCY-1]),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef DATA_MEM_STATS_EN
   logic [31:0] r_reads, r_writes, r_mis;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_reads  <= '0;
         r_writes <= '0;
         r_mis    <= '0;
      end else if (w_accept) begin
         if (w_is_rd && !w_misal && r_reads != '1) r_reads <= r_reads + 1'b1;
         if (w_is_wr && !w_misal && r_writes != '1) r_writes <= r_writes + 1'b1;
         if (w_misal && r_mis != '1) r_mis <= r_mis + 1'b1;
      end

   assign stat_reads      = r_reads;
   assign stat_writes     = r_writes;
   assign stat_misaligned = r_mis;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven vectors with a response scoreboard plus backpressure,
// latency and reset corner sequences.
module tb_data_mem_responder;
   import ppc_types::*;

   localparam int LAT = DATA_MEM_READ_LATENCY;

   typedef struct {
      logic [0:3]  wen;
      logic [0:3]  ren;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      logic        exp_v;
   } vec_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic [31:0] cur_exp_d = 0;
   logic        cur_exp_v = 0;
   logic [32:0] sb [$];
   int          n_assert = 0;
   int          n_fail = 0;
   vec_t        tv [16];
   logic [31:0] bp_addr [6];
   logic [31:0] bp_exp [6];
   int          acc, k;
`ifdef DATA_MEM_STATS_EN
   logic [31:0] stat_reads, stat_writes, stat_misaligned;
`endif

   data_mem_if bus ();

   data_mem_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DATA_MEM_STATS_EN
      ,
      .stat_reads      (stat_reads),
      .stat_writes     (stat_writes),
      .stat_misaligned (stat_misaligned)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (rst_n) begin
         if (bus.to_mem_valid && bus.to_mem_ready) sb.push_back({cur_exp_d, cur_exp_v});
         if (bus.from_mem_valid && bus.from_mem_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", {31'b0, bus.from_mem_valid}, 32'd0);
            else begin
               logic [32:0] e;
               e = sb.pop_front();
               chk("rdata", bus.mem_read_data, e[32:1]);
               chk("rdata_valid", {31'b0, bus.mem_read_data_valid}, {31'b0, e[0]});
            end
         end
      end

   task automatic idle();
      bus.to_mem_valid   = 0;
      bus.mem_write_en   = 0;
      bus.mem_read_en    = 0;
      bus.mem_address    = 0;
      bus.mem_write_data = 0;
   endtask

   task automatic send(input logic [0:3] wen, input logic [0:3] ren, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_v);
      int n;
      @(posedge clk); #1;
      bus.mem_write_en   = wen;
      bus.mem_read_en    = ren;
      bus.mem_address    = addr;
      bus.mem_write_data = wdata;
      cur_exp_d          = exp_d;
      cur_exp_v          = exp_v;
      bus.to_mem_valid   = 1;
      n = 0;
      @(negedge clk);
      while (!bus.to_mem_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept", {31'b0, bus.to_mem_ready}, 32'd1);
      @(posedge clk); #1;
      idle();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   initial begin
      tv[0]  = '{4'hF, 4'h0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      tv[1]  = '{4'h0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1};
      tv[2]  = '{4'hF, 4'h0, 32'h20,   32'h11223344, 32'h0,        1'b0};
      tv[3]  = '{4'h8, 4'h0, 32'h23,   32'hAB000000, 32'h0,        1'b0};
      tv[4]  = '{4'h0, 4'hF, 32'h20,   32'h0,        32'h112233AB, 1'b1};
      tv[5]  = '{4'h0, 4'h8, 32'h21,   32'h0,        32'h22000000, 1'b1};
      tv[6]  = '{4'hC, 4'h0, 32'h23,   32'hFFFF0000, 32'h0,        1'b0};
      tv[7]  = '{4'h0, 4'hF, 32'h20,   32'h0,        32'h112233AB, 1'b1};
      tv[8]  = '{4'h0, 4'h0, 32'h20,   32'h0,        32'h0,        1'b0};
      tv[9]  = '{4'hC, 4'hF, 32'h22,   32'hCDEF0000, 32'h0,        1'b0};
      tv[10] = '{4'h0, 4'hF, 32'h20,   32'h0,        32'h1122CDEF, 1'b1};
      tv[11] = '{4'h0, 4'hC, 32'h22,   32'h0,        32'hCDEF0000, 1'b1};
      tv[12] = '{4'h0, 4'hF, 32'h21,   32'h0,        32'h0,        1'b0};
      tv[13] = '{4'hF, 4'h0, 32'h1000, 32'h55555555, 32'h0,        1'b0};
      tv[14] = '{4'h0, 4'hF, 32'h0,    32'h0,        32'h55555555, 1'b1};
      tv[15] = '{4'h0, 4'h8, 32'h12,   32'h0,        32'hBE000000, 1'b1};
      bp_addr = '{32'h10, 32'h20, 32'h0, 32'h10, 32'h20, 32'h0};
      bp_exp  = '{32'hDEADBEEF, 32'h1122CDEF, 32'h55555555, 32'hDEADBEEF, 32'h1122CDEF, 32'h55555555};

      idle();
      bus.from_mem_ready = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_to_mem_ready", {31'b0, bus.to_mem_ready}, 32'd0);
      chk("rst_from_mem_valid", {31'b0, bus.from_mem_valid}, 32'd0);
      chk("rst_read_data", bus.mem_read_data, 32'd0);
      chk("rst_read_data_valid", {31'b0, bus.mem_read_data_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("ready_first_cycle", {31'b0, bus.to_mem_ready}, 32'd0);
      @(negedge clk);
      chk("ready_second_cycle", {31'b0, bus.to_mem_ready}, 32'd1);

      for (int i = 0; i < 16; i++)
         send(tv[i].wen, tv[i].ren, tv[i].addr, tv[i].wdata, tv[i].exp_d, tv[i].exp_v);
      drain();
`ifdef DATA_MEM_STATS_EN
      chk("stat_reads", stat_reads, 32'd8);
      chk("stat_writes", stat_writes, 32'd5);
      chk("stat_misaligned", stat_misaligned, 32'd2);
`endif

      send(4'h0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      k = 0;
      while (!bus.from_mem_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("latency_min", {31'b0, k >= LAT}, 32'd1);
      chk("latency_max", {31'b0, k <= LAT + 1}, 32'd1);
      drain();

      @(posedge clk); #1;
      bus.from_mem_ready = 0;
      bus.mem_read_en    = 4'hF;
      bus.mem_address    = bp_addr[0];
      cur_exp_d          = bp_exp[0];
      cur_exp_v          = 1;
      bus.to_mem_valid   = 1;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.to_mem_ready) acc++;
         @(posedge clk); #1;
         if (acc < 6) begin
            bus.mem_address = bp_addr[acc];
            cur_exp_d       = bp_exp[acc];
         end else bus.to_mem_valid = 0;
      end
      chk("bp_accepts", acc, 32'd4);
      repeat (3) @(negedge clk);
      chk("bp_hold_valid", {31'b0, bus.from_mem_valid}, 32'd1);
      chk("bp_hold_data", bus.mem_read_data, bp_exp[0]);
      bus.from_mem_ready = 1;
      k = 0;
      while (acc < 6 && k < 30) begin
         @(negedge clk);
         if (bus.to_mem_ready) acc++;
         @(posedge clk); #1;
         if (acc < 6) begin
            bus.mem_address = bp_addr[acc];
            cur_exp_d       = bp_exp[acc];
         end
         k++;
      end
      idle();
      chk("bp_total", acc, 32'd6);
      drain();

      bus.from_mem_ready = 0;
      for (int i = 0; i < 3; i++) send(4'h0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
      repeat (4) @(posedge clk);
      #2;
      chk("mid_pending_valid", {31'b0, bus.from_mem_valid}, 32'd1);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", {31'b0, bus.from_mem_valid}, 32'd0);
      chk("mid_rst_data", bus.mem_read_data, 32'd0);
      chk("mid_rst_ready", {31'b0, bus.to_mem_ready}, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      bus.from_mem_ready = 1;
      @(negedge clk);
      chk("mid_ready_first", {31'b0, bus.to_mem_ready}, 32'd0);
      @(negedge clk);
      chk("mid_ready_second", {31'b0, bus.to_mem_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_beat", {31'b0, bus.from_mem_valid}, 32'd0);
      end
      send(4'h0, 4'hF, 32'h20, 32'h0, 32'h1122CDEF, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
